// File: rtl/lfsr_gen.sv
// Maximal-length XNOR Fibonacci LFSR with loadable seed and terminal-match flag.
// Latency: state updates on the clk edge after reset/load/shift; LFSR_Done is combinational.
// Backpressure: none; enable=0 freezes the register and ignores seed_dv.
`timescale 1ns/1ps
module lfsr_gen #(
  parameter int NUM_BITS = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                seed_dv,
  input  logic [NUM_BITS-1:0] Seed_Data,
  output logic [NUM_BITS-1:0] LFSR_Data,
  output logic                LFSR_Done
);

  if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_width
    $error("lfsr_gen: NUM_BITS must be in 3..32");
  end

  // Bit t-1 set for each 1-based tap position t of the maximal-length polynomial.
  function automatic logic [31:0] tap_mask(input int n);
    logic [31:0] m;
    case (n)
      3:       m = 32'h0000_0006;
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  localparam logic [31:0]         TAP_MASK_FULL = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP_MASK      = TAP_MASK_FULL[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] state;
  logic                fb;

  // XNOR feedback keeps all-zeros in the sequence and makes all-ones the lockup.
  always_comb begin
    fb = ~(^(state & TAP_MASK));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
    end else if (enable) begin
      if (seed_dv) begin
        state <= Seed_Data;
      end else begin
        state <= {state[NUM_BITS-2:0], fb};
      end
    end
  end

  assign LFSR_Data = state;
  assign LFSR_Done = (state == Seed_Data);

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed vector table, period/hold sequences,
// randomized traffic against a tap-list reference model, and a width sweep.
`timescale 1ns/1ps
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, seed_dv;
  logic [8:0] seed_data;
  logic [8:0] lfsr_data;
  logic       lfsr_done;

  lfsr_gen #(.NUM_BITS(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .seed_dv   (seed_dv),
    .Seed_Data (seed_data),
    .LFSR_Data (lfsr_data),
    .LFSR_Done (lfsr_done)
  );

  // Width-sweep instances, always shifting from a zero seed.
  logic        rst_w, en_w;
  logic [2:0]  d3;
  logic [3:0]  d4;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic [3:0]  wdone;

  lfsr_gen #(.NUM_BITS(3)) u3 (
    .clk(clk), .reset(rst_w), .enable(en_w), .seed_dv(1'b0),
    .Seed_Data(3'b0), .LFSR_Data(d3), .LFSR_Done(wdone[0]));
  lfsr_gen #(.NUM_BITS(4)) u4 (
    .clk(clk), .reset(rst_w), .enable(en_w), .seed_dv(1'b0),
    .Seed_Data(4'b0), .LFSR_Data(d4), .LFSR_Done(wdone[1]));
  lfsr_gen #(.NUM_BITS(8)) u8 (
    .clk(clk), .reset(rst_w), .enable(en_w), .seed_dv(1'b0),
    .Seed_Data(8'b0), .LFSR_Data(d8), .LFSR_Done(wdone[2]));
  lfsr_gen #(.NUM_BITS(16)) u16 (
    .clk(clk), .reset(rst_w), .enable(en_w), .seed_dv(1'b0),
    .Seed_Data(16'b0), .LFSR_Data(d16), .LFSR_Done(wdone[3]));

  logic [31:0] wd [4];
  assign wd[0] = {29'b0, d3};
  assign wd[1] = {28'b0, d4};
  assign wd[2] = {24'b0, d8};
  assign wd[3] = {16'b0, d16};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: 1-based tap positions straight from the polynomial table.
  function automatic int tap_pos(input int n, input int k);
    int t[4];
    case (n)
      3:       t = '{3, 2, 0, 0};
      4:       t = '{4, 3, 0, 0};
      8:       t = '{8, 6, 5, 4};
      9:       t = '{9, 5, 0, 0};
      16:      t = '{16, 15, 13, 4};
      default: t = '{0, 0, 0, 0};
    endcase
    return t[k];
  endfunction

  function automatic logic [31:0] model_next(input int n, input logic [31:0] s);
    int          ones;
    logic [31:0] mask;
    logic [31:0] r;
    ones = 0;
    for (int k = 0; k < 4; k++) begin
      if (tap_pos(n, k) != 0 && s[tap_pos(n, k) - 1]) ones++;
    end
    mask = (32'd1 << n) - 32'd1;
    r    = (s << 1) & mask;
    r[0] = (ones % 2 == 0);
    return r;
  endfunction

  typedef struct {
    logic       rst;
    logic       en;
    logic       sdv;
    logic [8:0] seed;
    logic [8:0] exp_d;
    logic       exp_done;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] s;
  logic        seen [512];
  logic [31:0] hold_val;
  logic [31:0] ms [4];
  int          period [4];
  int          widths [4];
  logic [31:0] ones_val;

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    seed_dv   = 1'b0;
    seed_data = 9'h000;
    rst_w     = 1'b1;
    en_w      = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 9'h000, 9'h001, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 9'h000, 9'h003, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 9'h000, 9'h007, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 9'h000, 9'h00F, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 9'h000, 9'h01F, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 9'h000, 9'h03E, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 9'h0AA, 9'h0AA, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 9'h0AA, 9'h155, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 9'h0AA, 9'h155, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 9'h155, 9'h155, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 9'h123, 9'h000, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 9'h1FF, 9'h1FF, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 9'h1FF, 9'h1FF, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1};

    for (int i = 0; i < 15; i++) begin
      reset     = vecs[i].rst;
      enable    = vecs[i].en;
      seed_dv   = vecs[i].sdv;
      seed_data = vecs[i].seed;
      tick();
      check($sformatf("vec%0d_data", i), 32'(lfsr_data), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_done", i), 32'(lfsr_done), 32'(vecs[i].exp_done));
    end

    // LFSR_Done follows Seed_Data without a clock edge.
    reset     = 1'b0;
    enable    = 1'b0;
    seed_data = 9'h005;
    #1;
    check("done_comb_drop", 32'(lfsr_done), 32'd0);
    seed_data = 9'h000;
    #1;
    check("done_comb_rise", 32'(lfsr_done), 32'd1);

    // Full period from zero: distinct values, no lockup, Done only at the wrap.
    reset = 1'b1; enable = 1'b1; seed_dv = 1'b0; seed_data = 9'h000;
    tick();
    reset = 1'b0;
    s = 32'd0;
    for (int v = 0; v < 512; v++) seen[v] = 1'b0;
    seen[0] = 1'b1;
    for (int i = 1; i <= 511; i++) begin
      tick();
      s = model_next(9, s);
      check($sformatf("p9_data%0d", i), 32'(lfsr_data), s);
      check($sformatf("p9_done%0d", i), 32'(lfsr_done), (i == 511) ? 32'd1 : 32'd0);
      if (i < 511) begin
        check($sformatf("p9_lock%0d", i), 32'(lfsr_data == 9'h1FF), 32'd0);
        check($sformatf("p9_dup%0d", i), 32'(seen[lfsr_data]), 32'd0);
        seen[lfsr_data] = 1'b1;
      end
    end
    check("p9_wrap", 32'(lfsr_data), 32'd0);

    // Hold mid-sequence with seed_dv pulses.
    for (int i = 0; i < 37; i++) begin
      tick();
      s = model_next(9, s);
    end
    check("hold_pre", 32'(lfsr_data), s);
    hold_val = s;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seed_dv   = (i % 2 == 0);
      seed_data = 9'($urandom_range(0, 511));
      tick();
      check($sformatf("hold%0d", i), 32'(lfsr_data), hold_val);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 31) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      seed_dv   = ($urandom_range(0, 5) == 0);
      seed_data = 9'($urandom_range(0, 511));
      tick();
      if (reset)        s = 32'd0;
      else if (enable)  s = seed_dv ? 32'(seed_data) : model_next(9, s);
      check($sformatf("rnd%0d_data", i), 32'(lfsr_data), s);
      check($sformatf("rnd%0d_done", i), 32'(lfsr_done), 32'(s == 32'(seed_data)));
    end
    reset = 1'b0; enable = 1'b0; seed_dv = 1'b0;

    // Width sweep: periods for 3, 4, 8 and 16 bits, all in parallel.
    widths = '{3, 4, 8, 16};
    for (int k = 0; k < 4; k++) begin
      ms[k]     = 32'd0;
      period[k] = 0;
    end
    rst_w = 1'b1; en_w = 1'b1;
    tick();
    rst_w = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("w%0d_reset", widths[k]), wd[k], 32'd0);
    end
    for (int cyc = 1; cyc <= 70000; cyc++) begin
      if (period[0] != 0 && period[1] != 0 && period[2] != 0 && period[3] != 0) break;
      tick();
      for (int k = 0; k < 4; k++) begin
        if (period[k] == 0) begin
          ms[k]    = model_next(widths[k], ms[k]);
          ones_val = (32'd1 << widths[k]) - 32'd1;
          if (wd[k] !== ms[k] || wd[k] == ones_val)
            check($sformatf("w%0d_seq%0d", widths[k], cyc), wd[k], ms[k]);
          if (wd[k] == 32'd0) begin
            period[k] = cyc;
            check($sformatf("w%0d_done_wrap", widths[k]), 32'(wdone[k]), 32'd1);
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("w%0d_period", widths[k]), 32'(period[k]),
            (32'd1 << widths[k]) - 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
